// File: rtl/sigma_irq_ctrl.sv
// Interrupt controller: synchronizes, edge/level-qualifies, masks and prioritizes N_IRQ lines and
// presents one interrupt at a time to the CPU over a req/ack/done handshake.
module sigma_irq_ctrl #(
  parameter int unsigned N_IRQ = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             host_req_i,
  input  logic             host_we_i,
  input  logic [4:0]       host_addr_i,
  input  logic [31:0]      host_wdata_i,
  output logic             host_ack_o,
  output logic             host_resp_o,
  output logic [31:0]      host_rdata_o,
  output logic             irq_req_o,
  output logic [4:0]       irq_code_o,
  input  logic             irq_ack_i,
  input  logic             irq_done_i
);

  typedef enum logic [1:0] {StIdle, StReq, StSvc} state_e;

  localparam logic [2:0] RegPending = 3'd0;
  localparam logic [2:0] RegMode    = 3'd1;
  localparam logic [2:0] RegCur     = 3'd2;
  localparam logic [2:0] RegEnable  = 3'd4;

  logic [N_IRQ-1:0] sync1_q, sync2_q, prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mode_q, mode_d;
  logic [N_IRQ-1:0] enable_q, enable_d;
  state_e           state_q, state_d;
  logic [4:0]       code_q, code_d;
  logic             resp_q, resp_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr_en, rd_en;
  logic [2:0]       reg_sel;
  logic [N_IRQ-1:0] rise, clr, cand;
  logic [31:0]      ack_mask, rd_val;
  logic [4:0]       win_idx;
  logic             win_vld;

  always_comb begin
    wr_en    = host_req_i & host_we_i;
    rd_en    = host_req_i & ~host_we_i;
    reg_sel  = host_addr_i[4:2];
    rise     = sync2_q & ~prev_q;
    ack_mask = (state_q == StReq && irq_ack_i) ? (32'd1 << code_q) : 32'd0;
    clr      = ack_mask[N_IRQ-1:0];
    if (wr_en && reg_sel == RegPending) begin
      clr = clr | host_wdata_i[N_IRQ-1:0];
    end
    // Edge lines: a same-cycle set beats any clear. Level lines simply follow the synchronizer.
    pending_d = (mode_q & ((pending_q & ~clr) | rise)) | (~mode_q & sync2_q);
    mode_d    = mode_q;
    enable_d  = enable_q;
    if (wr_en && reg_sel == RegMode) begin
      mode_d = host_wdata_i[N_IRQ-1:0];
    end
    if (wr_en && reg_sel == RegEnable) begin
      enable_d = host_wdata_i[N_IRQ-1:0];
    end
  end

  always_comb begin
    cand    = pending_q & enable_q;
    win_vld = |cand;
    win_idx = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_idx = 5'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d = StReq;
          code_d  = win_idx;
        end
      end
      StReq: begin
        if (irq_ack_i) begin
          state_d = StSvc;
        end
      end
      StSvc: begin
        if (irq_done_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      RegPending: rd_val[N_IRQ-1:0] = pending_q;
      RegMode:    rd_val[N_IRQ-1:0] = mode_q;
      RegCur: begin
        if (state_q != StIdle) begin
          rd_val = {state_q == StSvc, 26'd0, code_q};
        end
      end
      RegEnable:  rd_val[N_IRQ-1:0] = enable_q;
      default:    rd_val = '0;
    endcase
    resp_d  = rd_en;
    rdata_d = rd_en ? rd_val : 32'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      mode_q    <= '0;
      enable_q  <= '0;
      state_q   <= StIdle;
      code_q    <= '0;
      resp_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      sync1_q   <= irq_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      enable_q  <= enable_d;
      state_q   <= state_d;
      code_q    <= code_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign host_ack_o   = host_req_i;
  assign host_resp_o  = resp_q;
  assign host_rdata_o = rdata_q;
  assign irq_req_o    = (state_q == StReq);
  assign irq_code_o   = code_q;

endmodule

// File: doc/sigma_irq_ctrl.md
# sigma_irq_ctrl

Interrupt controller between the sigma SoC interrupt sources (debounced IRQ button, GPIO, peripherals) and the RISC-V core's external interrupt input. It synchronizes, edge/level-qualifies, masks and prioritizes up to 32 lines. It presents one interrupt at a time to the CPU over a req/ack/done handshake. Firmware or UDM configures it through a 32-bit register slave at base 0x00100000; ENABLE sits at 0x00100010.

## Interface
- N_IRQ, 8: number of interrupt lines, 1..32; unused register bits read 0, writes ignored.
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- irq_i  in  N_IRQ  raw interrupt lines, asynchronous.
- host_req_i  in  1  register access request.
- host_we_i  in  1  1 = write.
- host_addr_i  in  5  byte offset; bits [1:0] ignored.
- host_wdata_i  in  32  write data; full-word only.
- host_ack_o  out  1  = host_req_i, combinational; accepted every cycle.
- host_resp_o  out  1  read-data valid, one cycle after an accepted read.
- host_rdata_o  out  32  read data, valid with host_resp_o; 0 otherwise.
- irq_req_o  out  1  interrupt request to the CPU.
- irq_code_o  out  5  line index being requested or serviced.
- irq_ack_i  in  1  CPU has taken the request.
- irq_done_i  in  1  CPU handler finished (mret).

## Operation
- Input path: 2-flop synchronizer per line, giving s2. Also one history flop, prev.
- Edge mode (MODE bit = 1):
  - A rising edge (s2 & ~prev) sets PENDING.
  - PENDING is cleared by W1C or on irq_ack_i for the accepted line.
  - If a set and a clear of the same bit occur in the same cycle, the set wins.
- Level mode (MODE bit = 0): PENDING = s2 each cycle. W1C and ack have no effect.
- Register map:
  - 0x00 PENDING: R/W1C.
  - 0x04 MODE: R/W.
  - 0x08 CUR: R; bit31 = in service, [4:0] = line.
  - 0x0C: reads 0.
  - 0x10 ENABLE: R/W.
  - Offsets >= 0x14: read 0, writes ignored.
- Candidate set = PENDING & ENABLE. Priority is fixed: lowest index wins.
- FSM:
  - IDLE: if the candidate set is non-zero, latch the winning index into irq_code_o and go to REQ.
  - REQ: irq_req_o = 1 and the code is frozen. When irq_ack_i is sampled, clear the edge-mode pending bit, set CUR.bit31 and go to SVC. The request is never withdrawn: clearing ENABLE or PENDING while in REQ does not drop irq_req_o.
  - SVC: irq_req_o = 0 and irq_code_o is held. On irq_done_i, clear CUR.bit31 and go to IDLE.
  - irq_ack_i outside REQ and irq_done_i outside SVC are ignored.
- IDLE always lasts at least one cycle, so back-to-back interrupts are separated by at least one idle cycle.
- Level-mode lines re-request after done if still asserted and enabled.

## Timing
- Reset values:
  - All registers 0, including synchronizers, prev, PENDING, MODE and ENABLE.
  - FSM in IDLE.
  - Outputs irq_req_o, irq_code_o, host_resp_o and host_rdata_o are 0.
- Because prev resets to 0, an edge-mode line held high across reset sets PENDING 3 cycles after reset release. It is masked until enabled.
- Reset asserted in any state returns the block to IDLE on the next edge and drops irq_req_o; the CPU handshake is abandoned.
- Latency from irq_i rising (setup before edge E0):
  - s2 = 1 after E1.
  - PENDING = 1 after E2.
  - irq_req_o = 1 after E3 (4 cycles, enabled line, FSM in IDLE).
- irq_ack_i sampled high at edge E: irq_req_o = 0 after E, and the PENDING bit is already clear in the same cycle.
- Register write takes effect at the accepting edge. A newly enabled pending line raises irq_req_o one cycle later.
- Read data reflects register state before the accepting edge and appears with host_resp_o on the next cycle.

## Test plan
- Reset and enable:
  - Write ENABLE = 0x4 and MODE = 0x4.
  - Pulse irq_i[2] high for 3 cycles.
  - Expect irq_req_o = 1 and irq_code_o = 2, 4 cycles after the rising edge.
  - Read 0x00: expect 0x4.
- Handshake:
  - Assert ack for 1 cycle: expect irq_req_o = 0 next cycle, PENDING = 0 and CUR = 0x80000002.
  - Assert irq_done_i: expect CUR = 0 and the FSM back in IDLE.
- Priority:
  - ENABLE = 0xFF, MODE = 0xFF. Raise lines 5 and 1 in the same cycle.
  - Expect code 1 first. After done, expect code 5 no earlier than 2 cycles later.
- Masking and W1C:
  - ENABLE = 0, raise line 3: expect PENDING = 0x8 and no request.
  - Write 0x8 to 0x00: expect PENDING = 0.
  - Repeat the edge, then set ENABLE = 0x8: expect a request next cycle.
- Level mode:
  - MODE = 0, ENABLE = 0x1. Hold irq_i[0] high through ack and done.
  - Expect a re-request after one IDLE cycle.
  - Drop the line: expect PENDING = 0 three cycles later.
- Reset mid-service:
  - Assert rst_i during SVC: expect irq_req_o = 0, CUR = 0 and ENABLE = 0 after one edge.
  - Assert stray ack/done while in IDLE: expect no state change.
